// File: rtl/tohost_monitor_if.sv
// Store-bus and console-handshake bundle between the core-side environment and tohost_monitor.
// The master side drives the core stores and the console ready signal; the slave side is the monitor.
`timescale 1ns/1ps
interface tohost_monitor_if;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cons_valid;
    logic [7:0]  cons_data;
    logic        cons_ready;

    modport master (output mem_we, mem_addr, mem_wdata, cons_ready,
                    input  cons_valid, cons_data);
    modport slave  (input  mem_we, mem_addr, mem_wdata, cons_ready,
                    output cons_valid, cons_data);
endinterface

// File: rtl/tohost_monitor.sv
// End-of-test responder on the core store bus: latches the tohost result, counts RUN cycles,
// enforces a watchdog and buffers console bytes in an 8-deep FIFO behind a valid/ready handshake.
`timescale 1ns/1ps
module tohost_monitor #(
    parameter logic [31:0] TOHOST_ADDR  = 32'h0000_0100,
    parameter logic [31:0] CONSOLE_ADDR = 32'h0000_0104,
    parameter int          TIMEOUT      = 220,
    parameter int          CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    tohost_monitor_if.slave  bus,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [30:0]      fail_code,
    output logic [CNT_W-1:0] cycle_count,
    output logic             cons_overflow
);

    typedef enum logic [1:0] {ST_RUN, ST_PASS, ST_FAIL, ST_TMO} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [30:0]      fail_code_q, fail_code_d;
    logic             done_q, done_d, pass_q, pass_d, timeout_q, timeout_d;

    logic [7:0]       fifo_mem [8];
    logic [2:0]       wptr_q, wptr_d, rptr_q, rptr_d;
    logic [3:0]       occ_q, occ_d;
    logic [7:0]       head_q, head_d;
    logic             valid_q, valid_d, ovf_q, ovf_d;

    logic in_run, tohost_st, push, pop, full, push_ok;

    assign in_run    = (state_q == ST_RUN);
    assign tohost_st = bus.mem_we && (bus.mem_addr == TOHOST_ADDR);
    assign push      = in_run && bus.mem_we && (bus.mem_addr == CONSOLE_ADDR);
    assign pop       = valid_q && bus.cons_ready;
    assign full      = (occ_q == 4'd8);
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign push_ok   = push && (!full || pop);

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        cnt_d       = cnt_q;
        fail_code_d = fail_code_q;
        if (in_run) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (tohost_st && bus.mem_wdata == 32'd1) begin
                state_d = ST_PASS;
            end else if (tohost_st && bus.mem_wdata[0]) begin
                state_d     = ST_FAIL;
                fail_code_d = bus.mem_wdata[31:1];
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                state_d = ST_TMO;
            end
        end
        done_d    = (state_d != ST_RUN);
        pass_d    = (state_d == ST_PASS);
        timeout_d = (state_d == ST_TMO);
    end

    always_comb begin
        wptr_d = push_ok ? wptr_q + 3'd1 : wptr_q;
        rptr_d = pop     ? rptr_q + 3'd1 : rptr_q;
        unique case ({push_ok, pop})
            2'b10:   occ_d = occ_q + 4'd1;
            2'b01:   occ_d = occ_q - 4'd1;
            default: occ_d = occ_q;
        endcase
        ovf_d   = ovf_q | (push && !push_ok);
        valid_d = (occ_d != 4'd0);
        // The head register is refilled from storage, or straight from the bus when the FIFO
        // was empty (or about to become empty) so the new byte appears one edge after the push.
        head_d = head_q;
        if (occ_d == 4'd0) begin
            head_d = 8'd0;
        end else if (pop) begin
            head_d = (occ_q == 4'd1) ? bus.mem_wdata[7:0] : fifo_mem[rptr_q + 3'd1];
        end else if (occ_q == 4'd0) begin
            head_d = bus.mem_wdata[7:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            fail_code_q <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            occ_q       <= '0;
            head_q      <= '0;
            valid_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fail_code_q <= fail_code_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            timeout_q   <= timeout_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            occ_q       <= occ_d;
            head_q      <= head_d;
            valid_q     <= valid_d;
            ovf_q       <= ovf_d;
        end
    end

    // NOTE: storage is not reset; the occupancy count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wptr_q] <= bus.mem_wdata[7:0];
    end

    assign done           = done_q;
    assign pass           = pass_q;
    assign timeout        = timeout_q;
    assign fail_code      = fail_code_q;
    assign cycle_count    = cnt_q;
    assign cons_overflow  = ovf_q;
    assign bus.cons_valid = valid_q;
    assign bus.cons_data  = head_q;

endmodule

// File: doc/tohost_monitor.md
# tohost_monitor

Synthesizable end-of-test responder that sits on the data-memory store bus of the single-cycle RISC-V core. It is the receiving end of the program-to-environment channel: the test program stores to a `tohost` word to report pass/fail and to a console word to emit characters. The block latches the result, counts cycles, enforces a watchdog, and buffers console bytes behind a valid/ready handshake. Benches and the FPGA wrapper then observe completion without hard-coded run lengths.

## Interface
- `TOHOST_ADDR`, default 32'h0000_0100: store address carrying the test result.
- `CONSOLE_ADDR`, default 32'h0000_0104: store address carrying one console byte in `mem_wdata[7:0]`.
- `TIMEOUT`, default 220: cycles allowed in RUN before the watchdog fires; must be ≥1.
- `CNT_W`, default 16: cycle counter width; `TIMEOUT` must be < 2^CNT_W.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `mem_we`  in  1  core data-memory write enable.
- `mem_addr`  in  32  core data-memory byte address.
- `mem_wdata`  in  32  core store data.
- `done`  out  1  sticky; high in any terminal state.
- `pass`  out  1  sticky; high only in PASS.
- `timeout`  out  1  sticky; high only in TMO.
- `fail_code`  out  31  `mem_wdata[31:1]` of the failing store; 0 otherwise.
- `cycle_count`  out  CNT_W  cycles spent in RUN, frozen at terminal entry.
- `cons_valid`  out  1  console FIFO non-empty.
- `cons_data`  out  8  FIFO head byte; valid only while `cons_valid` is high.
- `cons_ready`  in  1  consumer accepts the head byte.
- `cons_overflow`  out  1  sticky; a console byte was dropped.

## Operation
- States: RUN, PASS, FAIL, TMO. Reset enters RUN. PASS, FAIL and TMO are terminal and stay until the next reset.
- Address matching is exact on all 32 bits. A store is a cycle with `mem_we`=1.
- Tohost store in RUN:
  - value 1 → PASS.
  - odd value other than 1 → FAIL, and `fail_code` latches value>>1.
  - even value, including 0 → ignored; remain in RUN.
- Watchdog: in RUN, when `cycle_count`==TIMEOUT-1 and no decisive tohost store occurs that cycle, go to TMO.
- Same-cycle tohost store and watchdog expiry → the store wins: PASS or FAIL, never TMO.
- Tohost stores in any terminal state are ignored. `fail_code` never changes after it is latched.
- `cycle_count` increments once per cycle in RUN and holds in terminal states. It cannot wrap because RUN always exits by TIMEOUT.
- Console FIFO: 8 entries × 8 bits, 3-bit read/write pointers plus a 4-bit occupancy count, pointers wrap modulo 8.
  - Push: console store while in RUN.
  - Pop: `cons_valid` && `cons_ready`. Pops continue in terminal states, so the host can drain the FIFO after `done`.
  - Push when full and no pop that cycle → byte dropped, `cons_overflow` sets, FIFO contents unchanged.
  - Push and pop in the same cycle when full → both succeed; occupancy stays 8; no overflow.
  - Push and pop in the same cycle when empty → the pop is a no-op because `cons_valid` is 0; the push succeeds.
- Console stores in terminal states are ignored and do not set overflow.

## Timing
- Reset (`rst`=0, asynchronous) values:
  - `done`, `pass`, `timeout`, `cons_valid`, `cons_overflow` = 0.
  - `fail_code`, `cycle_count` = 0.
  - FIFO empty. `cons_data` = 0 while empty.
- Reset deassertion is released to the next rising edge. Reset asserted mid-run clears everything immediately, including queued console bytes.
- A store sampled at edge N:
  - flags are visible after edge N; `done` is high during cycle N+1;
  - `cycle_count` reads the number of RUN cycles up to and including cycle N.
- Watchdog: with no decisive store, `timeout` and `done` rise after the edge that ends RUN cycle TIMEOUT; `cycle_count` reads TIMEOUT.
- Console latency:
  - A byte pushed at edge N has `cons_valid` high and `cons_data` showing it after edge N.
  - `cons_data` comes from a registered head; no combinational path from `mem_*` to any output.
- Handshake: the FIFO holds `cons_data` stable while `cons_valid` is high and `cons_ready` is low.
- All outputs are registered.

## Test plan
- Reset, then store 1 to 0x100 in cycle 10 → `done`=`pass`=1 after that edge; `cycle_count`=11; `timeout`=0; `fail_code`=0.
- Store 0x7 to 0x100 → FAIL with `fail_code`=3, `pass`=0. Later store 1 to 0x100 → no change.
- Store 2 to 0x100 → ignored. No further stores → `timeout`=1 after 220 RUN cycles; `cycle_count`=220.
- Store 1 to 0x100 in the same cycle as watchdog expiry → `pass`=1, `timeout`=0.
- Push "ABCDEFGHI" (9 bytes) with `cons_ready`=0 → 8 bytes buffered, `cons_overflow`=1. Raise `cons_ready` → A..H drain one per cycle, then `cons_valid`=0.
- Full FIFO, push and pop in the same cycle → occupancy stays 8, no overflow. Then pulse `rst` low mid-stream → all outputs return to their reset values immediately.
